mdr_in_word_byte_seq: RTL and testbench

Word-to-byte sequencer on the store path into the 8-bit memory data register (MDR). It accepts a 16-bit word plus a byte address from the CPU side through a valid/ready handshake. It then writes the word into byte-wide memory as two acknowledged byte writes, high byte first, or as a single low-byte write in byte mode. It is the write-direction counterpart of the MDR read path that assembles words from bytes, and it uses the same byte order: the high byte goes to the lower address.

---
 rtl/mdr_in_word_byte_seq.sv | 152 +++++++++++++++
 tb/tb_mdr_in_word_byte_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mdr_in_word_byte_seq.sv
// mdr_in_word_byte_seq: splits a 16-bit store into byte writes for the MDR path.
// The word's high byte goes to addr and its low byte to addr+1. Byte mode
// writes only the low byte, to addr.
// All state changes on the falling clock edge, the same edge the MDR byte path uses.
// Optional feature: define MDR_IN_SKID_EN to add a one-entry skid buffer.
// With the buffer, back-to-back words stream at 2 cycles/word.
module mdr_in_word_byte_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] word_in,
    input  logic [15:0] addr_in,
    input  logic        byte_mode,
    input  logic        word_valid,
    output logic        word_ready,
    output logic [7:0]  byte_out,
    output logic [15:0] byte_addr,
    output logic        byte_we,
    input  logic        byte_ack,
    output logic        done,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] word_q;
    logic [15:0] addr_q;

    logic        accept;
    logic        last_ack;
    logic [15:0] ld_word;
    logic [15:0] ld_addr;
    logic        ld_mode;

`ifdef MDR_IN_SKID_EN
    logic        buf_full;
    logic [15:0] buf_word;
    logic [15:0] buf_addr;
    logic        buf_mode;

    // Ready whenever the skid entry is free; reset forces it low
    assign word_ready = ~buf_full & ~rst;

    // Next word to start: a buffered word has priority over the live inputs
    always_comb begin
        ld_word = word_in;
        ld_addr = addr_in;
        ld_mode = byte_mode;
        if (buf_full) begin
            ld_word = buf_word;
            ld_addr = buf_addr;
            ld_mode = buf_mode;
        end
    end
`else
    // Ready only while idle; reset forces it low
    assign word_ready = (state == IDLE) & ~rst;

    // Without a buffer the next word always comes straight from the inputs
    always_comb begin
        ld_word = word_in;
        ld_addr = addr_in;
        ld_mode = byte_mode;
    end
`endif

    assign accept   = word_valid & word_ready;
    assign last_ack = (state == LOW) & byte_ack;

`ifdef MDR_IN_SKID_EN
    // Skid entry: filled by an accept that cannot start at once, drained on final ack
    always_ff @(negedge clk) begin
        if (rst) begin
            buf_full <= 1'b0;
            buf_word <= 16'h0000;
            buf_addr <= 16'h0000;
            buf_mode <= 1'b0;
        end else if (buf_full) begin
            if (last_ack || state == IDLE) begin
                buf_full <= 1'b0;
            end
        end else if (accept && state != IDLE && !last_ack) begin
            buf_full <= 1'b1;
            buf_word <= word_in;
            buf_addr <= addr_in;
            buf_mode <= byte_mode;
        end
    end

    logic start_c;
    assign start_c = (state == IDLE) ? (accept | buf_full)
                                     : (last_ack & (buf_full | accept));
`else
    logic start_c;
    assign start_c = (state == IDLE) ? accept : 1'b0;
`endif

    // Sequencer FSM with registered byte-write outputs
    always_ff @(negedge clk) begin
        if (rst) begin
            state     <= IDLE;
            word_q    <= 16'h0000;
            addr_q    <= 16'h0000;
            byte_out  <= 8'h00;
            byte_addr <= 16'h0000;
            byte_we   <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (last_ack) begin
                done <= 1'b1;
            end
            if (start_c) begin
                state     <= ld_mode ? LOW : HIGH;
                word_q    <= ld_word;
                addr_q    <= ld_addr;
                byte_out  <= ld_mode ? ld_word[7:0] : ld_word[15:8];
                byte_addr <= ld_addr;
                byte_we   <= 1'b1;
                busy      <= 1'b1;
            end else begin
                case (state)
                    HIGH: begin
                        if (byte_ack) begin
                            state     <= LOW;
                            byte_out  <= word_q[7:0];
                            byte_addr <= 16'(addr_q + 16'd1);
                        end
                    end
                    LOW: begin
                        if (byte_ack) begin
                            state   <= IDLE;
                            byte_we <= 1'b0;
                            busy    <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        byte_we <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdr_in_word_byte_seq.sv
// Directed bench for mdr_in_word_byte_seq. Inputs change and outputs are
// sampled 1 time unit after each falling edge. The MDR_IN_SKID_EN macro
// selects the back-to-back expectations.
module tb_mdr_in_word_byte_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] word_in;
    logic [15:0] addr_in;
    logic        byte_mode;
    logic        word_valid;
    logic        word_ready;
    logic [7:0]  byte_out;
    logic [15:0] byte_addr;
    logic        byte_we;
    logic        byte_ack;
    logic        done;
    logic        busy;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    mdr_in_word_byte_seq dut (
        .clk        (clk),
        .rst        (rst),
        .word_in    (word_in),
        .addr_in    (addr_in),
        .byte_mode  (byte_mode),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .byte_out   (byte_out),
        .byte_addr  (byte_addr),
        .byte_we    (byte_we),
        .byte_ack   (byte_ack),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the write-port outputs as one bundle
    task automatic chk_out(input string tag, input logic we, input logic [7:0] b,
                           input logic [15:0] a, input logic d);
        chk({tag, ".we"}, 32'(byte_we), 32'(we));
        if (we) begin
            chk({tag, ".byte"}, 32'(byte_out), 32'(b));
            chk({tag, ".addr"}, 32'(byte_addr), 32'(a));
        end
        chk({tag, ".done"}, 32'(done), 32'(d));
    endtask

    task automatic edge1();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; word_in = '0; addr_in = '0; byte_mode = 1'b0;
        word_valid = 1'b0; byte_ack = 1'b0;
        edge1();
        edge1();
        // reset state
        chk("rst.we", 32'(byte_we), 32'd0);
        chk("rst.byte", 32'(byte_out), 32'h00);
        chk("rst.addr", 32'(byte_addr), 32'h0000);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.ready", 32'(word_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst.ready_after", 32'(word_ready), 32'd1);

        // Word BEEF at 1000, ack high
        byte_ack = 1'b1; word_in = 16'hBEEF; addr_in = 16'h1000; word_valid = 1'b1;
        edge1();
        word_valid = 1'b0;
        chk_out("w1.N", 1'b1, 8'hBE, 16'h1000, 1'b0);
        chk("w1.busy", 32'(busy), 32'd1);
        chk("w1.ready", 32'(word_ready), 32'd0);
        edge1();
        chk_out("w1.N1", 1'b1, 8'hEF, 16'h1001, 1'b0);
        edge1();
        chk_out("w1.N2", 1'b0, 8'h00, 16'h0000, 1'b1);
        chk("w1.idle_busy", 32'(busy), 32'd0);
        chk("w1.idle_ready", 32'(word_ready), 32'd1);
        edge1();
        chk_out("w1.N3", 1'b0, 8'h00, 16'h0000, 1'b0);

        // Byte mode
        word_in = 16'h12A5; addr_in = 16'h0040; byte_mode = 1'b1; word_valid = 1'b1;
        edge1();
        word_valid = 1'b0; byte_mode = 1'b0;
        chk_out("bm.N", 1'b1, 8'hA5, 16'h0040, 1'b0);
        edge1();
        chk_out("bm.N1", 1'b0, 8'h00, 16'h0000, 1'b1);
        edge1();
        chk_out("bm.N2", 1'b0, 8'h00, 16'h0000, 1'b0);

        // 55AA at FFFF with waits; low byte wraps to 0000
        byte_ack = 1'b0; word_in = 16'h55AA; addr_in = 16'hFFFF; word_valid = 1'b1;
        edge1();
        word_valid = 1'b0;
        chk_out("wr.N", 1'b1, 8'h55, 16'hFFFF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            edge1();
            chk_out("wr.hwait", 1'b1, 8'h55, 16'hFFFF, 1'b0);
        end
        byte_ack = 1'b1;
        edge1();
        byte_ack = 1'b0;
        chk_out("wr.low", 1'b1, 8'hAA, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            edge1();
            chk_out("wr.lwait", 1'b1, 8'hAA, 16'h0000, 1'b0);
        end
        byte_ack = 1'b1;
        edge1();
        chk_out("wr.end", 1'b0, 8'h00, 16'h0000, 1'b1);
        edge1();

        // Reset while in LOW with ack low
        word_in = 16'h1234; addr_in = 16'h2000; word_valid = 1'b1;
        edge1();
        word_valid = 1'b0;
        edge1();
        byte_ack = 1'b0;
        chk_out("rl.low", 1'b1, 8'h34, 16'h2001, 1'b0);
        edge1();
        rst = 1'b1;
        edge1();
        chk("rl.we", 32'(byte_we), 32'd0);
        chk("rl.byte", 32'(byte_out), 32'h00);
        chk("rl.addr", 32'(byte_addr), 32'h0000);
        chk("rl.done", 32'(done), 32'd0);
        chk("rl.busy", 32'(busy), 32'd0);
        rst = 1'b0;
        byte_ack = 1'b1;
        edge1();
        chk("rl.done2", 32'(done), 32'd0);
        chk("rl.ready", 32'(word_ready), 32'd1);

        // Inputs changed after accept must not leak into the bytes
        word_in = 16'hCAFE; addr_in = 16'h3000; word_valid = 1'b1;
        edge1();
        word_valid = 1'b0; word_in = 16'h0000; addr_in = 16'h7777;
        chk_out("lt.N", 1'b1, 8'hCA, 16'h3000, 1'b0);
        edge1();
        chk_out("lt.N1", 1'b1, 8'hFE, 16'h3001, 1'b0);
        edge1();
        chk_out("lt.N2", 1'b0, 8'h00, 16'h0000, 1'b1);
        edge1();

        // Back-to-back words, ack high
        word_in = 16'h1111; addr_in = 16'h4000; word_valid = 1'b1;
        edge1();
        word_in = 16'h2222; addr_in = 16'h5000;
        chk_out("bb.N", 1'b1, 8'h11, 16'h4000, 1'b0);
        edge1();
        chk_out("bb.N1", 1'b1, 8'h11, 16'h4001, 1'b0);
`ifdef MDR_IN_SKID_EN
        word_valid = 1'b0;
        edge1();
        chk_out("bb.N2", 1'b1, 8'h22, 16'h5000, 1'b1);
        edge1();
        chk_out("bb.N3", 1'b1, 8'h22, 16'h5001, 1'b0);
        edge1();
        chk_out("bb.N4", 1'b0, 8'h00, 16'h0000, 1'b1);
`else
        edge1();
        chk_out("bb.N2", 1'b0, 8'h00, 16'h0000, 1'b1);
        chk("bb.ready", 32'(word_ready), 32'd1);
        edge1();
        word_valid = 1'b0;
        chk_out("bb.N3", 1'b1, 8'h22, 16'h5000, 1'b0);
        edge1();
        chk_out("bb.N4", 1'b1, 8'h22, 16'h5001, 1'b0);
        edge1();
        chk_out("bb.N5", 1'b0, 8'h00, 16'h0000, 1'b1);
`endif
        edge1();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
